// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: merges never-stalling pipeline results with
// handshaked mul/div results, buffering the latter in a small FIFO with hazard lookup.
module wb_write_arbiter #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       PIPE_WE,
    input  logic [ADDR_W-1:0]          PIPE_ADDR,
    input  logic [DATA_W-1:0]          PIPE_DATA,
    input  logic                       MD_VALID,
    input  logic [ADDR_W-1:0]          MD_ADDR,
    input  logic [DATA_W-1:0]          MD_DATA,
    output logic                       MD_READY,
    input  logic [ADDR_W-1:0]          HAZ_ADDR1,
    input  logic [ADDR_W-1:0]          HAZ_ADDR2,
    output logic                       HAZ_HIT1,
    output logic                       HAZ_HIT2,
    output logic                       WRITE_ENABLE,
    output logic [ADDR_W-1:0]          WRITE_ADDR,
    output logic [DATA_W-1:0]          WRITE_DATA,
    output logic [$clog2(DEPTH):0]     PEND_COUNT
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count, count_next;
    logic [DEPTH-1:0]  entry_valid;

    logic pipe_wr, md_xfer, fifo_empty, pop, bypass, push;
    logic hit1, hit2;

    assign PEND_COUNT = count;
    assign MD_READY   = !RESET && (count < CNT_W'(DEPTH));

    always_comb begin
        pipe_wr    = PIPE_WE && (PIPE_ADDR != '0);
        md_xfer    = MD_VALID && MD_READY;
        fifo_empty = (count == '0);
        pop        = !pipe_wr && !fifo_empty;
        bypass     = !pipe_wr && fifo_empty && md_xfer && (MD_ADDR != '0);
        // x0 results finish the handshake but are dropped here
        push       = md_xfer && (MD_ADDR != '0) && !bypass;
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    // An entry is live when its distance from the read pointer is below the count
    always_comb begin
        entry_valid = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            entry_valid[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count);
    end

    always_comb begin
        hit1 = MD_VALID && (MD_ADDR == HAZ_ADDR1);
        hit2 = MD_VALID && (MD_ADDR == HAZ_ADDR2);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (mem_addr[i] == HAZ_ADDR1)) hit1 = 1'b1;
            if (entry_valid[i] && (mem_addr[i] == HAZ_ADDR2)) hit2 = 1'b1;
        end
        HAZ_HIT1 = hit1 && (HAZ_ADDR1 != '0);
        HAZ_HIT2 = hit2 && (HAZ_ADDR2 != '0);
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_addr[wr_ptr] <= MD_ADDR;
            mem_data[wr_ptr] <= MD_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            WRITE_ENABLE <= 1'b0;
            WRITE_ADDR   <= '0;
            WRITE_DATA   <= '0;
        end else begin
            count        <= count_next;
            WRITE_ENABLE <= pipe_wr || pop || bypass;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (pipe_wr) begin
                WRITE_ADDR <= PIPE_ADDR;
                WRITE_DATA <= PIPE_DATA;
            end else if (pop) begin
                WRITE_ADDR <= mem_addr[rd_ptr];
                WRITE_DATA <= mem_data[rd_ptr];
            end else if (bypass) begin
                WRITE_ADDR <= MD_ADDR;
                WRITE_DATA <= MD_DATA;
            end
        end
    end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: expected register-file writes go into a
// queue, and a negedge monitor compares every write the DUT presents.
module tb_wb_write_arbiter;
    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;
    logic [4:0]  haz_addr1, haz_addr2;
    logic        haz_hit1, haz_hit2;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [1:0]  pend_count;

    int checks = 0;
    int passed = 0;
    logic [36:0] exp_q[$];

    wb_write_arbiter #(.DEPTH(2), .ADDR_W(5), .DATA_W(32)) dut (
        .CLK(clk), .RESET(rst),
        .PIPE_WE(pipe_we), .PIPE_ADDR(pipe_addr), .PIPE_DATA(pipe_data),
        .MD_VALID(md_valid), .MD_ADDR(md_addr), .MD_DATA(md_data), .MD_READY(md_ready),
        .HAZ_ADDR1(haz_addr1), .HAZ_ADDR2(haz_addr2),
        .HAZ_HIT1(haz_hit1), .HAZ_HIT2(haz_hit2),
        .WRITE_ENABLE(write_enable), .WRITE_ADDR(write_addr), .WRITE_DATA(write_data),
        .PEND_COUNT(pend_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: the register file samples on negedge, so do we
    always @(negedge clk) begin
        if (!rst && write_enable) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {27'd0, write_addr, write_data}, 64'd0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("write", {27'd0, write_addr, write_data}, {27'd0, e});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic [4:0] a, input logic [31:0] d);
        pipe_we = 1'b1; pipe_addr = a; pipe_data = d;
    endtask

    task automatic md(input logic [4:0] a, input logic [31:0] d);
        md_valid = 1'b1; md_addr = a; md_data = d;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        pipe_we = 0; pipe_addr = 0; pipe_data = 0;
        md_valid = 0; md_addr = 0; md_data = 0;
        haz_addr1 = 0; haz_addr2 = 0;
        #7;
        chk("rst_we", 64'(write_enable), 64'd0);
        chk("rst_addr", 64'(write_addr), 64'd0);
        chk("rst_data", 64'(write_data), 64'd0);
        chk("rst_pend", 64'(pend_count), 64'd0);
        chk("rst_ready", 64'(md_ready), 64'd0);
        step();
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(md_ready), 64'd1);

        // T1 single pipeline write
        expect_wr(5'd5, 32'h0000_1234);
        pipe(5'd5, 32'h0000_1234);
        step();
        pipe_we = 0;
        chk("t1_we", 64'(write_enable), 64'd1);
        step();
        chk("t1_we_drop", 64'(write_enable), 64'd0);

        // T2 mul/div bypass with empty FIFO
        expect_wr(5'd7, 32'hDEAD_BEEF);
        md(5'd7, 32'hDEAD_BEEF);
        chk("t2_ready", 64'(md_ready), 64'd1);
        step();
        md_valid = 0;
        chk("t2_pend", 64'(pend_count), 64'd0);
        step();

        // T3 pipeline holds the port; FIFO fills, then drains in order
        expect_wr(5'd3, 32'h30); expect_wr(5'd3, 32'h31);
        expect_wr(5'd3, 32'h32); expect_wr(5'd3, 32'h33);
        expect_wr(5'd7, 32'h70); expect_wr(5'd8, 32'h80);
        expect_wr(5'd10, 32'hA0);
        pipe(5'd3, 32'h30); md(5'd7, 32'h70);
        step();
        chk("t3_pend1", 64'(pend_count), 64'd1);
        pipe(5'd3, 32'h31); md(5'd8, 32'h80);
        chk("t3_ready1", 64'(md_ready), 64'd1);
        step();
        chk("t3_pend2", 64'(pend_count), 64'd2);
        chk("t3_ready_full", 64'(md_ready), 64'd0);
        pipe(5'd3, 32'h32); md_valid = 0;
        step();
        pipe(5'd3, 32'h33);
        step();
        chk("t3_pend_hold", 64'(pend_count), 64'd2);
        pipe_we = 0;
        step();
        chk("t3_pend_pop", 64'(pend_count), 64'd1);
        chk("t3_ready_back", 64'(md_ready), 64'd1);
        md(5'd10, 32'hA0);
        step();
        chk("t3_pushpop", 64'(pend_count), 64'd1);
        md_valid = 0;
        step();
        chk("t3_empty", 64'(pend_count), 64'd0);
        step();

        // T4 x0 pipeline write does not block the FIFO; x0 mul/div is dropped
        expect_wr(5'd4, 32'h40); expect_wr(5'd9, 32'h90);
        pipe(5'd4, 32'h40); md(5'd9, 32'h90);
        step();
        chk("t4_pend1", 64'(pend_count), 64'd1);
        pipe(5'd0, 32'hFF); md(5'd0, 32'h55);
        chk("t4_ready", 64'(md_ready), 64'd1);
        step();
        chk("t4_pend0", 64'(pend_count), 64'd0);
        pipe_we = 0; md_valid = 0;
        step();
        step();

        // T5 asynchronous reset with a full FIFO
        expect_wr(5'd1, 32'h11); expect_wr(5'd1, 32'h12);
        pipe(5'd1, 32'h11); md(5'd13, 32'hD0);
        step();
        pipe(5'd1, 32'h12); md(5'd14, 32'hE0);
        step();
        pipe_we = 0; md_valid = 0;
        chk("t5_full", 64'(pend_count), 64'd2);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_we", 64'(write_enable), 64'd0);
        chk("t5_addr", 64'(write_addr), 64'd0);
        chk("t5_data", 64'(write_data), 64'd0);
        chk("t5_pend", 64'(pend_count), 64'd0);
        chk("t5_ready_in_rst", 64'(md_ready), 64'd0);
        #1;
        rst = 1'b0;
        #1;
        chk("t5_ready_after", 64'(md_ready), 64'd1);
        step();
        step();
        step();

        // T6 hazard lookup against buffered entry and offered result
        expect_wr(5'd2, 32'h20); expect_wr(5'd12, 32'hC0);
        pipe(5'd2, 32'h20); md(5'd12, 32'hC0);
        step();
        pipe_we = 0; md_valid = 0;
        haz_addr1 = 5'd12; haz_addr2 = 5'd0;
        #1;
        chk("t6_hit1", 64'(haz_hit1), 64'd1);
        chk("t6_hit2_x0", 64'(haz_hit2), 64'd0);
        haz_addr2 = 5'd17;
        md_addr = 5'd17; md_valid = 1'b1;
        #1;
        chk("t6_hit2_md", 64'(haz_hit2), 64'd1);
        md_addr = 5'd0; haz_addr2 = 5'd0;
        #1;
        chk("t6_hit2_md_x0", 64'(haz_hit2), 64'd0);
        md_valid = 0;
        step();
        chk("t6_hit1_drained", 64'(haz_hit1), 64'd0);
        step();
        step();

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
